// File: rtl/bnn_pkg.sv
// Shared BNN constants and pack-state encoding for the activation packer and BNN unit.
package bnn_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned DEF_LEN = 9;
   localparam int unsigned CNT_W   = 6;

   typedef enum logic [1:0] {
      PK_EMPTY,
      PK_FILL,
      PK_FULL
   } pack_state_t;

   // Pack lengths live in [1, WORD_W]; zero would never close a word.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [31:0] len);
      if (len == 32'd0) begin
         return CNT_W'(1);
      end else if (len > WORD_W) begin
         return CNT_W'(WORD_W);
      end else begin
         return len[CNT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/bnn_packer_if.sv
// Activation-in / packed-word-out handshake bundle for bnn_packer.
interface bnn_packer_if;
   import bnn_pkg::*;

   logic              in_valid;
   logic              in_bit;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_word;
   logic [CNT_W-1:0]  out_count;

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_word, out_count
   );

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_word, out_count
   );

endinterface

// File: rtl/bnn_packer.sv
// Packs 1-bit BNN activations LSB-first into words for the XNOR/popcount operand path.
// Optional BNN_PACK_STATS_EN adds a words_out handshake counter.
module bnn_packer
   import bnn_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              pl_WE,
   input  logic [31:0]       ExtImmE,
   input  logic              flush,
   bnn_packer_if.slave       bus,
   output logic              busy
`ifdef BNN_PACK_STATS_EN
   ,
   output logic [31:0]       words_out
`endif
);

   localparam int unsigned IdxW = $clog2(WORD_W);

   pack_state_t       state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  pack_len_q, pack_len_d;
   logic [CNT_W-1:0]  cur_len_q, cur_len_d;
   logic              accept;
   logic              drain;

   assign bus.in_ready  = (state_q != PK_FULL);
   assign bus.out_valid = (state_q == PK_FULL);
   assign bus.out_word  = bus.out_valid ? shreg_q : '0;
   assign bus.out_count = bus.out_valid ? cnt_q : '0;
   assign busy          = (state_q != PK_EMPTY);

   assign accept = bus.in_valid & bus.in_ready;
   assign drain  = bus.out_valid & bus.out_ready;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      cur_len_d  = cur_len_q;
      pack_len_d = pl_WE ? clamp_len(ExtImmE) : pack_len_q;

      unique case (state_q)
         PK_EMPTY: begin
            // Word length is frozen from the pre-write value when the first bit lands.
            if (accept) begin
               shreg_d[0] = bus.in_bit;
               cnt_d      = CNT_W'(1);
               cur_len_d  = pack_len_q;
               state_d    = (pack_len_q == CNT_W'(1)) ? PK_FULL : PK_FILL;
            end
         end
         PK_FILL: begin
            if (accept) begin
               shreg_d[cnt_q[IdxW-1:0]] = bus.in_bit;
               cnt_d                    = cnt_q + CNT_W'(1);
            end
            if ((cnt_d == cur_len_q) || flush) begin
               state_d = PK_FULL;
            end
         end
         PK_FULL: begin
            if (drain) begin
               state_d = PK_EMPTY;
               shreg_d = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = PK_EMPTY;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= PK_EMPTY;
         shreg_q    <= '0;
         cnt_q      <= '0;
         pack_len_q <= CNT_W'(DEF_LEN);
         cur_len_q  <= CNT_W'(DEF_LEN);
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         pack_len_q <= pack_len_d;
         cur_len_q  <= cur_len_d;
      end
   end

`ifdef BNN_PACK_STATS_EN
   logic [31:0] words_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         words_q <= '0;
      end else if (drain) begin
         words_q <= words_q + 32'd1;
      end
   end

   assign words_out = words_q;
`endif

endmodule

// File: tb/tb_bnn_packer.sv
// Directed scoreboard bench for bnn_packer: defaults, length clamps, backpressure, flush, reset.
module tb_bnn_packer;
   import bnn_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        pl_WE;
   logic [31:0] ExtImmE;
   logic        flush;
   logic        busy;
`ifdef BNN_PACK_STATS_EN
   logic [31:0] words_out;
`endif

   bnn_packer_if bus ();

   bnn_packer dut (
      .clk       (clk),
      .reset     (reset),
      .pl_WE     (pl_WE),
      .ExtImmE   (ExtImmE),
      .flush     (flush),
      .bus       (bus),
      .busy      (busy)
`ifdef BNN_PACK_STATS_EN
      ,
      .words_out (words_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] w;
      logic [5:0]  c;
   } exp_t;

   exp_t sb[$];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   n_words = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are observed on the falling edge too.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_range(input logic [31:0] pat, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.in_valid = 1'b1;
         bus.in_bit   = pat[i];
         step();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic set_len(input logic [31:0] v);
      pl_WE   = 1'b1;
      ExtImmE = v;
      step();
      pl_WE   = 1'b0;
   endtask

   task automatic push(input logic [31:0] w, input int c);
      exp_t e;
      e.w = w;
      e.c = 6'(c);
      sb.push_back(e);
   endtask

   task automatic drain(input string tag);
      exp_t e;
      int   t = 0;
      while (bus.out_valid !== 1'b1 && t < 50) begin
         step();
         t++;
      end
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL %s_sb: observed empty queue expected an entry", tag);
         e = '0;
      end else begin
         e = sb.pop_front();
      end
      check({tag, "_word"}, bus.out_word, e.w);
      check({tag, "_count"}, 32'(bus.out_count), 32'(e.c));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      n_words++;
      check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
`ifdef BNN_PACK_STATS_EN
      check({tag, "_stats"}, words_out, 32'(n_words));
`endif
   endtask

   initial begin
      logic [31:0] pat;
      logic [31:0] pat2;
      bit          seq[9] = '{1, 0, 1, 1, 0, 0, 1, 0, 1};

      reset         = 1'b1;
      pl_WE         = 1'b0;
      ExtImmE       = '0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      step();
      reset = 1'b0;

      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_word", bus.out_word, 32'd0);
      check("rst_out_count", 32'(bus.out_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Default 9-bit word, then 10 cycles of backpressure with bits offered.
      pat = '0;
      for (int i = 0; i < 9; i++) pat[i] = seq[i];
      push(32'h0000_014D, 9);
      send_range(pat, 0, 7);
      check("def_not_yet", 32'(bus.out_valid), 32'd0);
      check("def_busy", 32'(busy), 32'd1);
      send_range(pat, 8, 8);
      check("def_latency", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check("bp_word", bus.out_word, 32'h0000_014D);
      end
      bus.in_valid = 1'b0;
      drain("def9");
      check("def_idle", 32'(busy), 32'd0);

      // Full-width word, clamp above WORD_W, and zero length meaning one bit.
      set_len(32'd32);
      push(32'hFFFF_FFFF, 32);
      send_range(32'hFFFF_FFFF, 0, 31);
      drain("len32");
      set_len(32'd100);
      pat = $urandom;
      push(pat, 32);
      send_range(pat, 0, 31);
      drain("len_clamp");
      set_len(32'd0);
      push(32'd1, 1);
      send_range(32'd1, 0, 0);
      check("len1_latency", 32'(bus.out_valid), 32'd1);
      drain("len1_a");
      push(32'd0, 1);
      send_range(32'd0, 0, 0);
      drain("len1_b");

      // Flush of a partial word, flush while empty, flush with a same-cycle bit.
      set_len(32'd9);
      push(32'h0000_000B, 4);
      send_range(32'b1011, 0, 3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drain("flush4");
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_empty_valid", 32'(bus.out_valid), 32'd0);
      check("flush_empty_busy", 32'(busy), 32'd0);
      send_range(32'b01, 0, 1);
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      flush        = 1'b1;
      step();
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      push(32'd5, 3);
      drain("flush_bit");

      // Flush while a full word is held must not change it.
      pat = $urandom & 32'h0000_01FF;
      push(pat, 9);
      send_range(pat, 0, 8);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drain("flush_full");

      // Mid-word length write only affects the following word.
      pat  = $urandom & 32'h0000_01FF;
      pat2 = $urandom & 32'h0000_001F;
      send_range(pat, 0, 2);
      set_len(32'd5);
      send_range(pat, 3, 7);
      check("midlen_open", 32'(bus.out_valid), 32'd0);
      send_range(pat, 8, 8);
      push(pat, 9);
      drain("midlen_old");
      push(pat2, 5);
      send_range(pat2, 0, 4);
      drain("midlen_new");

      // Reset mid-word discards everything and restores the default length.
      set_len(32'd9);
      send_range(32'h3F, 0, 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_words = 0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_word", bus.out_word, 32'd0);
      check("midrst_count", 32'(bus.out_count), 32'd0);
`ifdef BNN_PACK_STATS_EN
      check("midrst_stats", words_out, 32'd0);
`endif
      step();
      step();
      check("midrst_quiet", 32'(bus.out_valid), 32'd0);
      pat = $urandom & 32'h0000_01FF;
      push(pat, 9);
      send_range(pat, 0, 7);
      check("postrst_open", 32'(bus.out_valid), 32'd0);
      send_range(pat, 8, 8);
      drain("postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
